// File: rtl/mem_stage_param.sv
// mem_stage_param: memory stage behind AGEX. It holds one request at a time.
// ALU-pass ops, and every op when WAIT_CYCLES = 0, finish at the edge that
// accepts them. Loads and stores with WAIT_CYCLES > 0 hold the stage BUSY for
// WAIT_CYCLES cycles. The memory access happens at the completion edge.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_valid/in_ready   request handshake; in_ready is high only while IDLE
//   in_op/in_size/...   request fields: op, size, sign mode, addr, data, dest
//   out_*               result latch; out_valid pulses for one cycle
//   fwd_*               forwarding view of the result latch
module mem_stage_param #(
    parameter int DBITS       = 32,
    parameter int DMEM_WORDS  = 1024,
    parameter int REGNOBITS   = 5,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [1:0]           in_size,
    input  logic                 in_unsigned,
    input  logic [DBITS-1:0]     in_addr,
    input  logic [DBITS-1:0]     in_wdata,
    input  logic [DBITS-1:0]     in_aluout,
    input  logic                 in_wr_reg,
    input  logic [REGNOBITS-1:0] in_wregno,
    output logic                 out_valid,
    output logic [DBITS-1:0]     out_result,
    output logic                 out_wr_reg,
    output logic [REGNOBITS-1:0] out_wregno,
    output logic                 out_misalign,
    output logic                 fwd_valid,
    output logic [REGNOBITS-1:0] fwd_wregno,
    output logic [DBITS-1:0]     fwd_value
);
    localparam int         AW        = $clog2(DMEM_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit         HAS_WAIT  = (WAIT_CYCLES != 0);
    localparam logic [1:0] OP_LOAD   = 2'd1;
    localparam logic [1:0] OP_STORE  = 2'd2;

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic [1:0]           op;
        logic [1:0]           size;
        logic                 uns;
        logic [DBITS-1:0]     addr;
        logic [DBITS-1:0]     wdata;
        logic [DBITS-1:0]     aluout;
        logic                 wr_reg;
        logic [REGNOBITS-1:0] wregno;
    } req_t;

    logic [DBITS-1:0] mem [DMEM_WORDS];

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    req_t                 req_q, req_d, req_in, cur;
    logic                 out_valid_q, out_valid_d;
    logic [DBITS-1:0]     out_result_q, out_result_d;
    logic                 out_wr_reg_q, out_wr_reg_d;
    logic [REGNOBITS-1:0] out_wregno_q, out_wregno_d;
    logic                 out_misalign_q, out_misalign_d;

    logic             accept, complete, is_mem, misalign, mem_we;
    logic [AW-1:0]    widx;
    logic [DBITS-1:0] rd_word, lane, ld_val, wd_al, wr_word;
    logic [3:0]       be;
    logic             unused_addr_hi;

    always_comb begin
        req_in.op     = in_op;
        req_in.size   = in_size;
        req_in.uns    = in_unsigned;
        req_in.addr   = in_addr;
        req_in.wdata  = in_wdata;
        req_in.aluout = in_aluout;
        req_in.wr_reg = in_wr_reg;
        req_in.wregno = in_wregno;

        // While BUSY the captured request drives the datapath; while IDLE
        // the live inputs do, so immediate completions need no extra cycle.
        cur      = (state_q == BUSY) ? req_q : req_in;
        accept   = in_valid && (state_q == IDLE);
        is_mem   = (cur.op == OP_LOAD) || (cur.op == OP_STORE);
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        complete = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mem && HAS_WAIT) begin
                        req_d   = req_in;
                        cnt_d   = WAIT_INIT;
                        state_d = BUSY;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    complete = 1'b1;
                    cnt_d    = 4'd0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Address bits above the memory index wrap around.
        widx           = cur.addr[AW+1:2];
        unused_addr_hi = ^cur.addr[DBITS-1:AW+2];
        rd_word        = mem[widx];
        misalign       = is_mem && (((cur.size == 2'd1) && cur.addr[0]) ||
                                    (cur.size[1] && (cur.addr[1:0] != 2'b00)));

        // Aligned halves have addr[0] = 0, so one byte-granular shift serves
        // both byte and half lane selection.
        lane = rd_word >> {cur.addr[1:0], 3'b000};
        case (cur.size)
            2'd0:    ld_val = cur.uns ? {{(DBITS-8){1'b0}}, lane[7:0]}
                                      : {{(DBITS-8){lane[7]}}, lane[7:0]};
            2'd1:    ld_val = cur.uns ? {{(DBITS-16){1'b0}}, lane[15:0]}
                                      : {{(DBITS-16){lane[15]}}, lane[15:0]};
            default: ld_val = rd_word;
        endcase

        // Store data replicated across lanes; byte enables pick the lanes.
        case (cur.size)
            2'd0: begin
                be    = 4'b0001 << cur.addr[1:0];
                wd_al = {4{cur.wdata[7:0]}};
            end
            2'd1: begin
                be    = 4'b0011 << {cur.addr[1], 1'b0};
                wd_al = {2{cur.wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wd_al = cur.wdata;
            end
        endcase
        for (int i = 0; i < 4; i++)
            wr_word[8*i +: 8] = be[i] ? wd_al[8*i +: 8] : rd_word[8*i +: 8];

        // A reset at the completion edge aborts the write.
        mem_we = complete && (cur.op == OP_STORE) && !misalign && !reset;

        out_valid_d    = complete;
        out_result_d   = out_result_q;
        out_wr_reg_d   = out_wr_reg_q;
        out_wregno_d   = out_wregno_q;
        out_misalign_d = out_misalign_q;
        if (complete) begin
            out_wregno_d   = cur.wregno;
            out_misalign_d = misalign;
            out_wr_reg_d   = cur.wr_reg && !misalign;
            if (misalign || (cur.op == OP_STORE))
                out_result_d = '0;
            else if (cur.op == OP_LOAD)
                out_result_d = ld_val;
            else
                out_result_d = cur.aluout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            req_q          <= '0;
            out_valid_q    <= 1'b0;
            out_result_q   <= '0;
            out_wr_reg_q   <= 1'b0;
            out_wregno_q   <= '0;
            out_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_q          <= req_d;
            out_valid_q    <= out_valid_d;
            out_result_q   <= out_result_d;
            out_wr_reg_q   <= out_wr_reg_d;
            out_wregno_q   <= out_wregno_d;
            out_misalign_q <= out_misalign_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[widx] <= wr_word;
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_wr_reg   = out_wr_reg_q;
    assign out_wregno   = out_wregno_q;
    assign out_misalign = out_misalign_q;
    assign fwd_valid    = out_valid_q && out_wr_reg_q;
    assign fwd_wregno   = out_wregno_q;
    assign fwd_value    = out_result_q;
endmodule

// File: tb/tb_mem_stage_param.sv
// Self-checking bench for mem_stage_param with default parameters
// (WAIT_CYCLES = 2, DMEM_WORDS = 1024). Directed scenarios plus a randomized
// run checked against a byte-addressed reference memory.
module tb_mem_stage_param;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_unsigned, in_wr_reg;
  logic [1:0]  in_op, in_size;
  logic [31:0] in_addr, in_wdata, in_aluout;
  logic [4:0]  in_wregno;
  logic        out_valid, out_wr_reg, out_misalign, fwd_valid;
  logic [31:0] out_result, fwd_value;
  logic [4:0]  out_wregno, fwd_wregno;

  mem_stage_param dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_aluout(in_aluout),
    .in_wr_reg(in_wr_reg), .in_wregno(in_wregno), .out_valid(out_valid),
    .out_result(out_result), .out_wr_reg(out_wr_reg), .out_wregno(out_wregno),
    .out_misalign(out_misalign), .fwd_valid(fwd_valid),
    .fwd_wregno(fwd_wregno), .fwd_value(fwd_value)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference memory: 4 KiB of bytes, i.e. the aliased address space.
  logic [7:0] mb [4096];

  logic [31:0] r_res, r_fval;
  logic        r_wr, r_mis, r_fv, r_rdy;
  logic [4:0]  r_wno, r_fno;
  int          r_lat, r_low;

  // Issue one request at the current cycle and follow it to completion.
  // r_lat is measured from the acceptance cycle; a value of 20 means timeout.
  task automatic do_req(input logic [1:0] op, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] alu,
                        input logic wr, input logic [4:0] wno);
    in_valid = 1'b1; in_op = op; in_size = size; in_unsigned = uns;
    in_addr = addr; in_wdata = wdata; in_aluout = alu; in_wr_reg = wr;
    in_wregno = wno;
    @(posedge clk); #1;
    in_valid = 1'b0;
    r_lat = 1; r_low = 0;
    while (!out_valid && r_lat < 20) begin
      if (!in_ready) r_low++;
      @(posedge clk); #1;
      r_lat++;
    end
    r_res = out_result; r_wr = out_wr_reg; r_mis = out_misalign;
    r_wno = out_wregno; r_fv = fwd_valid; r_fno = fwd_wregno;
    r_fval = fwd_value; r_rdy = in_ready;
  endtask

  function automatic logic [31:0] mdl_load(input logic [1:0] size,
                                           input logic uns, input int a);
    int v;
    if (size == 2'd0) begin
      v = mb[a];
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = mb[a] + 256 * mb[a+1];
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
    end
    return 32'(v);
  endfunction

  task automatic mdl_store(input logic [1:0] size, input int a,
                           input logic [31:0] d);
    int n;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) mb[a+i] = d[8*i +: 8];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL rst_result got %h exp 0", out_result); end
    checks++; if (out_wr_reg !== 1'b0) begin errors++; $display("FAIL rst_wr_reg got %b exp 0", out_wr_reg); end
    checks++; if (out_wregno !== 5'd0) begin errors++; $display("FAIL rst_wregno got %0d exp 0", out_wregno); end
    checks++; if (out_misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign got %b exp 0", out_misalign); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", in_ready); end
    checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL rst_fwd_valid got %b exp 0", fwd_valid); end
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    do_req(2'd2, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0);
    checks++; if (r_lat != W + 1) begin errors++; $display("FAIL st_latency got %0d exp %0d", r_lat, W + 1); end
    checks++; if (r_low != W) begin errors++; $display("FAIL st_ready_low got %0d exp %0d", r_low, W); end
    checks++; if (r_rdy !== 1'b1) begin errors++; $display("FAIL st_ready_done got %b exp 1", r_rdy); end
    checks++; if (r_res !== 32'h0) begin errors++; $display("FAIL st_result got %h exp 0", r_res); end
    do_req(2'd1, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 5'd5);
    checks++; if (r_res !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_word got %h exp deadbeef", r_res); end
    checks++; if (r_lat != W + 1) begin errors++; $display("FAIL ld_latency got %0d exp %0d", r_lat, W + 1); end
    checks++; if (r_fv !== 1'b1 || r_fno !== 5'd5) begin errors++; $display("FAIL ld_fwd got %b/%0d exp 1/5", r_fv, r_fno); end
  endtask

  task automatic test_byte();
    do_req(2'd2, 2'd0, 1'b0, 32'h13, 32'hAAAAAA80, 32'h0, 1'b0, 5'd0);
    do_req(2'd1, 2'd0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 5'd3);
    checks++; if (r_res !== 32'hFFFFFF80) begin errors++; $display("FAIL ld_byte_s got %h exp ffffff80", r_res); end
    do_req(2'd1, 2'd0, 1'b1, 32'h13, 32'h0, 32'h0, 1'b1, 5'd3);
    checks++; if (r_res !== 32'h00000080) begin errors++; $display("FAIL ld_byte_u got %h exp 00000080", r_res); end
    do_req(2'd1, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 5'd3);
    checks++; if (r_res !== 32'h80ADBEEF) begin errors++; $display("FAIL ld_after_byte got %h exp 80adbeef", r_res); end
  endtask

  task automatic test_misalign();
    do_req(2'd1, 2'd1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 5'd4);
    checks++; if (r_mis !== 1'b1) begin errors++; $display("FAIL mis_flag got %b exp 1", r_mis); end
    checks++; if (r_wr !== 1'b0) begin errors++; $display("FAIL mis_wr_reg got %b exp 0", r_wr); end
    checks++; if (r_res !== 32'h0) begin errors++; $display("FAIL mis_result got %h exp 0", r_res); end
    do_req(2'd2, 2'd2, 1'b0, 32'h12, 32'h55555555, 32'h0, 1'b1, 5'd4);
    checks++; if (r_mis !== 1'b1) begin errors++; $display("FAIL mis_st_flag got %b exp 1", r_mis); end
    do_req(2'd1, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 5'd4);
    checks++; if (r_res !== 32'h80ADBEEF) begin errors++; $display("FAIL mis_mem got %h exp 80adbeef", r_res); end
    checks++; if (r_mis !== 1'b0) begin errors++; $display("FAIL mis_clear got %b exp 0", r_mis); end
  endtask

  task automatic test_alu();
    do_req(2'd0, 2'd0, 1'b0, 32'h11, 32'h0, 32'h1234, 1'b1, 5'd7);
    checks++; if (r_lat != 1) begin errors++; $display("FAIL alu_latency got %0d exp 1", r_lat); end
    checks++; if (r_low != 0 || r_rdy !== 1'b1) begin errors++; $display("FAIL alu_ready got %0d/%b exp 0/1", r_low, r_rdy); end
    checks++; if (r_fv !== 1'b1) begin errors++; $display("FAIL alu_fwd_valid got %b exp 1", r_fv); end
    checks++; if (r_fno !== 5'd7) begin errors++; $display("FAIL alu_fwd_wregno got %0d exp 7", r_fno); end
    checks++; if (r_fval !== 32'h1234) begin errors++; $display("FAIL alu_fwd_value got %h exp 1234", r_fval); end
    checks++; if (r_mis !== 1'b0) begin errors++; $display("FAIL alu_misalign got %b exp 0", r_mis); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL alu_pulse got %b exp 0", out_valid); end
    checks++; if (out_result !== 32'h1234) begin errors++; $display("FAIL alu_hold got %h exp 1234", out_result); end
    do_req(2'd3, 2'd2, 1'b0, 32'h0, 32'h0, 32'hCAFE, 1'b1, 5'd9);
    checks++; if (r_lat != 1 || r_res !== 32'hCAFE) begin errors++; $display("FAIL op3_pass got %0d/%h exp 1/cafe", r_lat, r_res); end
  endtask

  task automatic test_reset_busy();
    do_req(2'd2, 2'd2, 1'b0, 32'h20, 32'h5A5A5A5A, 32'h0, 1'b0, 5'd0);
    in_valid = 1'b1; in_op = 2'd2; in_size = 2'd2; in_addr = 32'h20;
    in_wdata = 32'h11111111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rb_busy got %b exp 0", in_ready); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rb_after got %b/%b exp 0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rb_no_valid got %b exp 0", out_valid); end
    do_req(2'd1, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 5'd1);
    checks++; if (r_res !== 32'h5A5A5A5A) begin errors++; $display("FAIL rb_mem got %h exp 5a5a5a5a", r_res); end
  endtask

  task automatic test_alias();
    do_req(2'd2, 2'd2, 1'b0, 32'h1010, 32'h0BADF00D, 32'h0, 1'b0, 5'd0);
    do_req(2'd1, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 5'd2);
    checks++; if (r_res !== 32'h0BADF00D) begin errors++; $display("FAIL alias got %h exp 0badf00d", r_res); end
  endtask

  task automatic test_random();
    logic [1:0]  op, size;
    logic        uns, wr, mis;
    logic [31:0] addr, wd, alu, eres;
    logic [4:0]  wno;
    int          a, elat;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      do_req(2'd2, 2'd2, 1'b0, 32'(4 * i), wd, 32'h0, 1'b0, 5'd0);
      mdl_store(2'd2, 4 * i, wd);
    end
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3)); size = 2'($urandom_range(0, 3));
      uns = 1'($urandom); wr = 1'($urandom); wno = 5'($urandom);
      a = $urandom_range(0, 60);
      addr = 32'(a) + ($urandom_range(0, 3) << 12);
      wd = $urandom; alu = $urandom;
      mis = (op == 2'd1 || op == 2'd2) &&
            ((size == 2'd1 && a % 2 != 0) || (size >= 2'd2 && a % 4 != 0));
      elat = (op == 2'd1 || op == 2'd2) ? W + 1 : 1;
      if (mis || op == 2'd2) eres = 32'h0;
      else if (op == 2'd1) eres = mdl_load(size, uns, a);
      else eres = alu;
      do_req(op, size, uns, addr, wd, alu, wr, wno);
      if (op == 2'd2 && !mis) mdl_store(size, a, wd);
      checks++; if (r_res !== eres) begin errors++; $display("FAIL rnd_result #%0d op %0d got %h exp %h", n, op, r_res, eres); end
      checks++; if (r_lat != elat) begin errors++; $display("FAIL rnd_latency #%0d got %0d exp %0d", n, r_lat, elat); end
      checks++; if (r_mis !== mis || r_wr !== (wr && !mis) || r_wno !== wno) begin
        errors++; $display("FAIL rnd_flags #%0d got %b/%b/%0d exp %b/%b/%0d", n, r_mis, r_wr, r_wno, mis, wr && !mis, wno);
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_size = 2'd0;
    in_unsigned = 1'b0; in_addr = 32'h0; in_wdata = 32'h0; in_aluout = 32'h0;
    in_wr_reg = 1'b0; in_wregno = 5'd0;
    test_reset();
    test_store_load();
    test_byte();
    test_misalign();
    test_alu();
    test_reset_busy();
    test_alias();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
